// File: rtl/operand_stepper.sv
// rtl/operand_stepper.sv - pushbutton/auto-scan stepper producing operand addresses and ALU opcode
module operand_stepper #(
    parameter int ADDR_W          = 3,
    parameter int OP_W            = 3,
    parameter int OP_MAX          = 7,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SCAN_CYCLES     = 50000000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              btn_a_i,
    input  logic              btn_b_i,
    input  logic              btn_op_i,
    input  logic              auto_i,
    output logic [ADDR_W-1:0] addra_o,
    output logic [ADDR_W-1:0] addrb_o,
    output logic [OP_W-1:0]   operacion_o,
    output logic              tick_o
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PS_W = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(SCAN_CYCLES - 1);
    localparam logic [OP_W-1:0] OP_TOP  = OP_W'(OP_MAX);

    typedef enum logic {
        MANUAL,
        SCAN
    } state_t;

    // bit order in the conditioning vectors: 0 = btn_a, 1 = btn_b, 2 = btn_op, 3 = auto
    logic [3:0]      sync_meta;
    logic [3:0]      sync_q;
    logic [2:0]      stable;
    logic [2:0]      stable_d;
    logic [DB_W-1:0] db_cnt [3];
    logic [2:0]      press;
    logic [2:0]      pend;
    logic [2:0]      req;
    logic            auto_s;
    logic [PS_W-1:0] presc;
    state_t          state;

    logic [ADDR_W-1:0] addra_inc;
    logic [ADDR_W-1:0] addrb_inc;
    logic [OP_W-1:0]   op_inc;

    // two-flop synchroniser for every raw input
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= {auto_i, btn_op_i, btn_b_i, btn_a_i};
            sync_q    <= sync_meta;
        end
    end

    // debounce: the stable value only follows the synced value after DEBOUNCE_CYCLES of disagreement
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            stable_d <= stable;
            for (int i = 0; i < 3; i++) begin
                if (sync_q[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync_q[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // a press is a rising edge of the debounced level; presses deferred behind a tick are re-offered
    always_comb begin
        press     = stable & ~stable_d;
        req       = press | pend;
        auto_s    = sync_q[3];
        addra_inc = addra_o + ADDR_W'(1);
        addrb_inc = addrb_o + ADDR_W'(1);
        op_inc    = (operacion_o >= OP_TOP) ? '0 : operacion_o + OP_W'(1);
    end

    // mode FSM with registered outputs; tick_o marks the cycle new values appear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= MANUAL;
            presc       <= '0;
            pend        <= '0;
            addra_o     <= '0;
            addrb_o     <= '0;
            operacion_o <= '0;
            tick_o      <= 1'b0;
        end else begin
            tick_o <= 1'b0;
            case (state)
                MANUAL: begin
                    presc <= '0;
                    if (auto_s) begin
                        state <= SCAN;
                        pend  <= '0;
                    end else if (tick_o) begin
                        // keep tick_o from going high twice in a row: hold new presses one cycle
                        pend <= req;
                    end else begin
                        pend <= '0;
                        if (req[0]) addra_o     <= addra_inc;
                        if (req[1]) addrb_o     <= addrb_inc;
                        if (req[2]) operacion_o <= op_inc;
                        tick_o <= |req;
                    end
                end
                SCAN: begin
                    pend <= '0;
                    if (!auto_s) begin
                        state <= MANUAL;
                        presc <= '0;
                    end else if (presc == PS_LAST) begin
                        // mixed-radix step: addrb is the least significant digit
                        presc   <= '0;
                        tick_o  <= 1'b1;
                        addrb_o <= addrb_inc;
                        if (addrb_o == '1) begin
                            addra_o <= addra_inc;
                            if (addra_o == '1) begin
                                operacion_o <= op_inc;
                            end
                        end
                    end else begin
                        presc <= presc + PS_W'(1);
                    end
                end
                default: begin
                    state <= MANUAL;
                    presc <= '0;
                    pend  <= '0;
                end
            endcase
        end
    end

endmodule
